// File: rtl/crc_checker.sv
// Receive-side CRC-16 checker: strips the two trailing CRC bytes, forwards the payload,
// and pulses crc_ok / crc_err once the message end is seen.
//
//  state | meaning
//  ------+----------------------------------------------------------------
//  IDLE  | no message in progress, pipe empty
//  ONE   | one byte held in b_new
//  TWO   | two bytes held; each new byte pushes b_old out to q
//  CHECK | message ended, {b_old,b_new} is the received CRC; result issued
module crc_checker #(
    parameter logic [15:0] POLY    = 16'h1021,
    parameter logic [15:0] INIT    = 16'hFFFF,
    parameter int          MAX_LEN = 255
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] d,
    input  logic       d_rdy,
    input  logic       msg_end,
    output logic [7:0] q,
    output logic       q_rdy,
    output logic       crc_ok,
    output logic       crc_err,
    output logic [7:0] msg_len,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        CHECK = 2'd3
    } state_t;

    // One spare count value above MAX_LEN marks an overlong message.
    localparam logic [8:0] CNT_MAX = 9'(MAX_LEN);
    localparam logic [8:0] CNT_SAT = 9'(MAX_LEN + 1);

    state_t      state, state_nx;
    logic [7:0]  b_old, b_old_nx;
    logic [7:0]  b_new, b_new_nx;
    logic [15:0] crc, crc_nx;
    logic [8:0]  cnt, cnt_nx;
    logic [7:0]  q_nx;
    logic        q_rdy_nx;
    logic        crc_ok_nx;
    logic        crc_err_nx;
    logic [7:0]  msg_len_nx;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (r[15]) r = (r << 1) ^ POLY;
            else       r = r << 1;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            b_old   <= 8'h00;
            b_new   <= 8'h00;
            crc     <= INIT;
            cnt     <= 9'd0;
            q       <= 8'h00;
            q_rdy   <= 1'b0;
            crc_ok  <= 1'b0;
            crc_err <= 1'b0;
            msg_len <= 8'h00;
        end else begin
            state   <= state_nx;
            b_old   <= b_old_nx;
            b_new   <= b_new_nx;
            crc     <= crc_nx;
            cnt     <= cnt_nx;
            q       <= q_nx;
            q_rdy   <= q_rdy_nx;
            crc_ok  <= crc_ok_nx;
            crc_err <= crc_err_nx;
            msg_len <= msg_len_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        b_old_nx   = b_old;
        b_new_nx   = b_new;
        crc_nx     = crc;
        cnt_nx     = cnt;
        q_nx       = q;
        q_rdy_nx   = 1'b0;
        crc_ok_nx  = 1'b0;
        crc_err_nx = 1'b0;
        msg_len_nx = msg_len;

        case (state)
            IDLE: begin
                if (d_rdy) begin
                    b_new_nx = d;
                    // A byte with msg_end is a one-byte message: too short to hold a CRC.
                    if (msg_end) crc_err_nx = 1'b1;
                    else         state_nx   = ONE;
                end
            end

            ONE: begin
                if (d_rdy) begin
                    b_old_nx = b_new;
                    b_new_nx = d;
                    state_nx = msg_end ? CHECK : TWO;
                end else if (msg_end) begin
                    crc_err_nx = 1'b1;
                    state_nx   = IDLE;
                end
            end

            TWO: begin
                if (d_rdy) begin
                    q_nx     = b_old;
                    q_rdy_nx = 1'b1;
                    crc_nx   = crc_upd(crc, b_old);
                    if (cnt != CNT_SAT) cnt_nx = cnt + 9'd1;
                    b_old_nx = b_new;
                    b_new_nx = d;
                end
                if (msg_end) state_nx = CHECK;
            end

            CHECK: begin
                if (crc == {b_old, b_new} && cnt <= CNT_MAX) crc_ok_nx  = 1'b1;
                else                                        crc_err_nx = 1'b1;
                msg_len_nx = (cnt > 9'd255) ? 8'hFF : cnt[7:0];
                crc_nx     = INIT;
                cnt_nx     = 9'd0;
                if (d_rdy) begin
                    b_new_nx = d;
                    state_nx = ONE;
                end else begin
                    state_nx = IDLE;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
